muxn_pipe: RTL

MUXN_PIPE -- requirements
Module: muxn_pipe

---
 rtl/muxn_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muxn_pipe.sv
// ---------------------------------------------------------------------------
// muxn_pipe -- registered N-to-1 multiplexer with valid/ready handshakes.
//
// Each accepted beat (in_valid && in_ready) captures input s of the packed
// bus d into the output register.  A select at or beyond NUM_IN captures an
// all-zero word and sets the sticky sel_err flag.  Results are delivered in
// accept order when out_valid && out_ready.
//
// Build option:
//   MUXN_PIPE_SKID_EN  undefined (default): one output register, in_ready is
//                      combinational (!out_valid || out_ready).
//                      defined: registered in_ready backed by a one-entry
//                      skid register, so out_ready never reaches in_ready
//                      combinationally.
//
// Parameters:
//   WIDTH   data width per input
//   NUM_IN  number of data inputs (2..16)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//
// Ports:
//   clk        clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   d          packed inputs, input i at d[i*WIDTH +: WIDTH]
//   s          select index, sampled with d on accept
//   in_valid   upstream offers d/s
//   in_ready   block can accept this cycle
//   y          registered selected data
//   out_valid  y holds an undelivered result
//   out_ready  downstream accepts y
//   sel_err    sticky: an out-of-range select was accepted
//   err_clr    synchronous clear of sel_err (a simultaneous new error wins)
// ---------------------------------------------------------------------------
module muxn_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]        s,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_oob;
    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;
    logic             sel_err_q;

    // Selection: out-of-range indices leave the all-zero default in place.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(s) == i) begin
                sel_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oob = (int'(s) >= NUM_IN);
    assign accept  = in_valid && in_ready;
    assign deliver = out_valid_q && out_ready;

    // Sticky select error; a new error on the same edge beats err_clr.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_oob) begin
            sel_err_q <= 1'b1;
        end else if (err_clr) begin
            sel_err_q <= 1'b0;
        end
    end

`ifdef MUXN_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             skid_full_q;
    logic             in_ready_q;

    // Output and skid control.  in_ready_q mirrors !skid_full_q but is its
    // own flop so in_ready has no logic behind it.  Invariant: skid_full_q
    // implies out_valid_q, and no accept can happen while the skid is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (skid_full_q) begin
            if (deliver) begin
                y_q         <= skid_q;
                skid_full_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                y_q         <= sel_data;
                out_valid_q <= 1'b1;
            end else begin
                // Output stalled this cycle: park the beat accepted on the
                // strength of last cycle's registered in_ready.
                skid_full_q <= 1'b1;
                in_ready_q  <= 1'b0;
            end
        end else if (deliver) begin
            out_valid_q <= 1'b0;
        end
    end

    // NOTE: the skid payload has no reset; skid_full_q alone says whether it
    // holds anything, so clearing the flag discards the entry.
    always_ff @(posedge clk) begin
        if (accept && out_valid_q && !out_ready) begin
            skid_q <= sel_data;
        end
    end

    assign in_ready = in_ready_q;
`else
    // Single output register: load on accept, empty on a delivery with no
    // replacement.  Accept and delivery together replace y at full rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            y_q         <= sel_data;
            out_valid_q <= 1'b1;
        end else if (deliver) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
`endif

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule
